// File: rtl/dct_pkg.sv
// Shared widths, counts and FSM encoding for the DCT block sequencer.
// Pure declarations: no latency, no flow control.
package dct_pkg;
    localparam int SAMPLE_W        = 8;
    localparam int COEF_W          = 19;
    localparam int NUM_COEF        = 8;
    localparam int IDX_W           = 3;
    localparam int CNT_W           = 6;
    localparam int DCT_LATENCY_DEF = 10;

    typedef enum logic [1:0] {
        ST_COLLECT  = 2'd0,
        ST_WAIT_OUT = 2'd1,
        ST_RUN      = 2'd2,
        ST_CAPTURE  = 2'd3
    } seq_state_e;
endpackage

// File: rtl/dct_block_sequencer_if.sv
// Sample input, DCT unit fan-out/fan-in and coefficient output of the sequencer.
// Slave side is the sequencer; master side is its environment.
interface dct_block_sequencer_if;
    import dct_pkg::*;

    logic [SAMPLE_W-1:0]                in_data;
    logic                               in_valid;
    logic                               in_ready;
    logic [NUM_COEF-1:0][SAMPLE_W-1:0]  blk_sample;
    logic                               dct_en;
    logic                               dct_cs;
    logic [NUM_COEF-1:0][COEF_W-1:0]    z;
    logic [COEF_W-1:0]                  coef_data;
    logic [IDX_W-1:0]                   coef_idx;
    logic                               coef_valid;
    logic                               coef_last;
    logic                               coef_ready;
    logic                               busy;

    modport master (
        output in_data, in_valid, z, coef_ready,
        input  in_ready, blk_sample, dct_en, dct_cs,
               coef_data, coef_idx, coef_valid, coef_last, busy
    );

    modport slave (
        input  in_data, in_valid, z, coef_ready,
        output in_ready, blk_sample, dct_en, dct_cs,
               coef_data, coef_idx, coef_valid, coef_last, busy
    );
endinterface

// File: rtl/dct_coef_emitter.sv
// Holds one block of coefficients and streams them out as idx 0..7; first valid the cycle after load.
// Holds data/idx while coef_ready is low; free_o tells the FSM a new block may be computed.
module dct_coef_emitter
    import dct_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            load_i,
    input  logic [NUM_COEF-1:0][COEF_W-1:0] z_i,
    input  logic                            coef_ready_i,
    output logic [COEF_W-1:0]               coef_data_o,
    output logic [IDX_W-1:0]                coef_idx_o,
    output logic                            coef_valid_o,
    output logic                            coef_last_o,
    output logic                            full_o,
    output logic                            free_o
);
    logic [NUM_COEF-1:0][COEF_W-1:0] coef_q, coef_d;
    logic [IDX_W-1:0]                rd_idx_q, rd_idx_d;
    logic                            full_q, full_d;
    logic                            hs;
    logic                            last_hs;

    assign hs      = full_q && coef_ready_i;
    assign last_hs = hs && (rd_idx_q == IDX_W'(NUM_COEF-1));

    // Shift register keeps the output word itself registered: coef_q[0] is always the head.
    always_comb begin
        coef_d   = coef_q;
        rd_idx_d = rd_idx_q;
        full_d   = full_q;
        if (load_i) begin
            coef_d   = z_i;
            rd_idx_d = '0;
            full_d   = 1'b1;
        end else if (hs) begin
            coef_d   = {{COEF_W{1'b0}}, coef_q[NUM_COEF-1:1]};
            rd_idx_d = rd_idx_q + 1'b1;
            if (last_hs) begin
                full_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_q   <= '0;
            rd_idx_q <= '0;
            full_q   <= 1'b0;
        end else begin
            coef_q   <= coef_d;
            rd_idx_q <= rd_idx_d;
            full_q   <= full_d;
        end
    end

    assign coef_data_o  = coef_q[0];
    assign coef_idx_o   = rd_idx_q;
    assign coef_valid_o = full_q;
    assign coef_last_o  = full_q && (rd_idx_q == IDX_W'(NUM_COEF-1));
    assign full_o       = full_q;
    // A final handshake this cycle frees the register as far as the FSM is concerned.
    assign free_o       = !full_q || last_hs;
endmodule

// File: rtl/dct_block_sequencer.sv
// Gathers 8 samples, drives the DCT units for DCT_LATENCY cycles, emits 8 coefficients (8th accept -> first valid: DCT_LATENCY+2).
// in_ready drops outside COLLECT; a finished block waits in WAIT_OUT until the emitter drains.
module dct_block_sequencer
    import dct_pkg::*;
#(
    parameter int DCT_LATENCY = DCT_LATENCY_DEF
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    dct_block_sequencer_if.slave  bus
);
    seq_state_e                        state_q, state_d;
    logic [IDX_W-1:0]                  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [NUM_COEF-1:0][SAMPLE_W-1:0] blk_q, blk_d;
    logic                              in_ready_q, in_ready_d;
    logic                              dct_en_q, dct_en_d;
    logic                              accept;
    logic                              cnt_done;
    logic                              load;
    logic                              em_full;
    logic                              em_free;

    assign accept   = bus.in_valid && in_ready_q;
    assign cnt_done = (cnt_q == CNT_W'(DCT_LATENCY - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_COLLECT;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            blk_q      <= '0;
            in_ready_q <= 1'b0;
            dct_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            blk_q      <= blk_d;
            in_ready_q <= in_ready_d;
            dct_en_q   <= dct_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_COLLECT: begin
                if (accept && (wr_ptr_q == IDX_W'(NUM_COEF-1))) begin
                    state_d = em_free ? ST_RUN : ST_WAIT_OUT;
                end
            end
            ST_WAIT_OUT: begin
                if (em_free) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_done) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_d = ST_COLLECT;
            default:    state_d = ST_COLLECT;
        endcase
    end

    // Handshake and DCT controls are registered from the next state so they read 0 during reset.
    always_comb begin
        in_ready_d = (state_d == ST_COLLECT);
        dct_en_d   = (state_d == ST_RUN);
        load       = (state_q == ST_CAPTURE);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        blk_d    = blk_q;
        cnt_d    = (state_q == ST_RUN && !cnt_done) ? cnt_q + 1'b1 : '0;
        if (accept) begin
            blk_d[wr_ptr_q] = bus.in_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
    end

    dct_coef_emitter u_emitter (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (load),
        .z_i          (bus.z),
        .coef_ready_i (bus.coef_ready),
        .coef_data_o  (bus.coef_data),
        .coef_idx_o   (bus.coef_idx),
        .coef_valid_o (bus.coef_valid),
        .coef_last_o  (bus.coef_last),
        .full_o       (em_full),
        .free_o       (em_free)
    );

    assign bus.in_ready   = in_ready_q;
    assign bus.blk_sample = blk_q;
    assign bus.dct_en     = dct_en_q;
    assign bus.dct_cs     = dct_en_q;
    assign bus.busy       = (state_q != ST_COLLECT) || em_full;
endmodule

// File: tb/tb_dct_block_sequencer.sv
// Bench for dct_block_sequencer: DCT stub, block-level reference queue, per-cycle output compare.
`timescale 1ns/1ps
module tb_dct_block_sequencer;
    import dct_pkg::*;

    localparam int LAT = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dct_block_sequencer_if bus();

    dct_block_sequencer #(.DCT_LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // DCT stub: z_k = (k+1)*sum(block), valid only after LAT cycles of dct_en.
    int en_cycles = 0;
    int stub_sum;
    always @(posedge clk) en_cycles <= bus.dct_en ? en_cycles + 1 : 0;
    always_comb begin
        stub_sum = 0;
        for (int k = 0; k < NUM_COEF; k++) stub_sum += int'($signed(bus.blk_sample[k]));
        for (int k = 0; k < NUM_COEF; k++)
            bus.z[k] = (en_cycles >= LAT) ? COEF_W'((k + 1) * stub_sum) : 19'h2AAAA;
    end

    int n_chk = 0;
    int n_pass = 0;
    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // coef_ready driver
    int   rdy_mode = 0;
    logic rdy_man  = 1'b1;
    initial begin
        bus.coef_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.coef_ready = 1'b1;
                1:       bus.coef_ready = ($urandom_range(0, 3) != 0);
                default: bus.coef_ready = rdy_man;
            endcase
        end
    end

    // Reference model: every completed block of accepted samples yields 8 expected coefficients.
    typedef struct packed {
        logic [COEF_W-1:0] data;
        logic [IDX_W-1:0]  idx;
    } exp_t;
    exp_t expq[$];
    int   cur[$];
    int   last_blk[NUM_COEF];
    int   got[$];
    logic              prev_hold = 1'b0;
    logic [COEF_W-1:0] prev_data;
    logic [IDX_W-1:0]  prev_idx;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            expq.delete();
            cur.delete();
            prev_hold = 1'b0;
        end else begin
            if (bus.coef_valid && bus.coef_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_coef", bus.coef_idx, -1);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("coef_data", bus.coef_data, e.data);
                    chk("coef_idx", bus.coef_idx, e.idx);
                    chk("coef_last", bus.coef_last, (e.idx == 3'd7));
                end
                got.push_back(int'($signed(bus.coef_data)));
            end
            if (prev_hold) begin
                chk("hold_valid", bus.coef_valid, 1);
                chk("hold_data", bus.coef_data, prev_data);
                chk("hold_idx", bus.coef_idx, prev_idx);
            end
            prev_hold = bus.coef_valid && !bus.coef_ready;
            prev_data = bus.coef_data;
            prev_idx  = bus.coef_idx;
            chk("en_while_emitting", bus.dct_en && bus.coef_valid, 0);
            if (bus.dct_en) begin
                logic ok;
                ok = 1'b1;
                for (int k = 0; k < NUM_COEF; k++)
                    if (int'($signed(bus.blk_sample[k])) != last_blk[k]) ok = 1'b0;
                chk("blk_presented", ok, 1);
            end
            if (bus.in_valid && bus.in_ready) begin
                cur.push_back(int'($signed(bus.in_data)));
                if (cur.size() == NUM_COEF) begin
                    int s;
                    s = 0;
                    foreach (cur[i]) s += cur[i];
                    for (int k = 0; k < NUM_COEF; k++) begin
                        exp_t e;
                        e.data = COEF_W'((k + 1) * s);
                        e.idx  = IDX_W'(k);
                        expq.push_back(e);
                        last_blk[k] = cur[k];
                    end
                    cur.delete();
                end
            end
        end
    end

    task automatic send_sample(input logic [SAMPLE_W-1:0] d);
        int t;
        t = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            t++;
            if (t > 300) begin
                chk("in_ready_timeout", bus.in_ready, 1);
                break;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_seq(input int first, input int step, input int n);
        for (int i = 0; i < n; i++) send_sample(SAMPLE_W'(first + i * step));
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++) send_sample(SAMPLE_W'($urandom_range(0, 255)));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (expq.size() != 0 || bus.coef_valid || bus.busy) begin
            @(negedge clk);
            t++;
            if (t > 500) begin
                chk("drain_timeout", expq.size(), 0);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_dct_en"}, bus.dct_en, 0);
        chk({tag, "_dct_cs"}, bus.dct_cs, 0);
        chk({tag, "_coef_valid"}, bus.coef_valid, 0);
        chk({tag, "_coef_data"}, bus.coef_data, 0);
        chk({tag, "_coef_idx"}, bus.coef_idx, 0);
        chk({tag, "_coef_last"}, bus.coef_last, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_blk_sample"}, bus.blk_sample, 0);
    endtask

    initial begin
        int s, n, en, cs, v, h0;
        logic [COEF_W-1:0] saved;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;

        #12 check_zero_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single block 1..8: latency, enable length and literal coefficients.
        s = got.size();
        send_seq(1, 1, 8);
        n = 0; en = 0; cs = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (bus.dct_en) en++;
            if (bus.dct_cs) cs++;
            if (bus.coef_valid) break;
        end
        chk("first_valid_latency", n, LAT + 2);
        chk("dct_en_cycles", en, LAT);
        chk("dct_cs_cycles", cs, LAT);
        @(posedge clk); #1;
        wait_drain();
        chk("blk1_count", got.size() - s, 8);
        chk("blk1_idx0", got[s], 36);
        chk("blk1_idx1", got[s+1], 72);
        chk("blk1_idx7", got[s+7], 288);

        // All -128: sign preserved over 19 bits.
        s = got.size();
        send_seq(-128, 0, 8);
        wait_drain();
        chk("neg_idx0", got[s], -1024);
        chk("neg_idx7", got[s+7], -8192);

        // Backpressure on idx 3, next block parks in WAIT_OUT.
        rdy_mode = 2;
        rdy_man  = 1'b1;
        send_rand(8);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.coef_valid && bus.coef_idx == 3'd2) break;
        end
        rdy_man = 1'b0;
        @(posedge clk); #2;
        chk("stall_idx", bus.coef_idx, 3);
        saved = bus.coef_data;
        send_rand(8);
        repeat (3) begin
            @(negedge clk);
            chk("wait_in_ready", bus.in_ready, 0);
            chk("wait_dct_en", bus.dct_en, 0);
            chk("wait_busy", bus.busy, 1);
        end
        chk("stall_idx_after", bus.coef_idx, 3);
        chk("stall_data_after", bus.coef_data, saved);
        rdy_man = 1'b1;
        v = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.coef_valid && bus.coef_ready && bus.coef_idx == 3'd7) begin
                chk("run_not_before_last", bus.dct_en, 0);
                @(negedge clk);
                chk("run_after_last", bus.dct_en, 1);
                v = 1;
                break;
            end
        end
        chk("saw_last_handshake", v, 1);
        @(posedge clk); #1;
        wait_drain();

        // Back-to-back streaming, then the same with random coef_ready.
        rdy_mode = 0;
        h0 = got.size();
        send_rand(32);
        wait_drain();
        chk("stream_count", got.size() - h0, 32);
        rdy_mode = 1;
        h0 = got.size();
        send_rand(24);
        wait_drain();
        chk("rand_ready_count", got.size() - h0, 24);
        rdy_mode = 0;

        // Reset at RUN count 4.
        send_rand(8);
        repeat (5) @(negedge clk);
        chk("midrun_dct_en", bus.dct_en, 1);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("midrun");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        v = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.coef_valid) v++;
        end
        chk("no_valid_after_reset", v, 0);
        @(posedge clk); #1;

        // Reset mid-collect, then a clean 1..8 block.
        send_rand(5);
        pulse_reset();
        @(posedge clk); #1;
        s = got.size();
        send_seq(1, 1, 8);
        wait_drain();
        chk("post_reset_count", got.size() - s, 8);
        chk("post_reset_idx0", got[s], 36);
        chk("post_reset_idx7", got[s+7], 288);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
